// File: rtl/rv_pkg.sv
// Shared RV64I+Zba pipeline types: result-source encoding, ALU opcodes and the
// decode control word carried from ID into EX.
package rv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam logic [3:0] ADD    = 4'd0;
  localparam logic [3:0] SUB    = 4'd1;
  localparam logic [3:0] AND    = 4'd2;
  localparam logic [3:0] OR     = 4'd3;
  localparam logic [3:0] SH1ADD = 4'd4;
  localparam logic [3:0] SH2ADD = 4'd5;
  localparam logic [3:0] SH3ADD = 4'd6;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        branch;
    logic        jump;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-side registered outputs,
// hazard controls and performance counters.
interface id_ex_stage_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             ValidD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             ALUSrcD;
  logic [3:0]       ALUControlD;
  logic             BranchD;
  logic             JumpD;
  logic [XLEN-1:0]  RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]       Rs1D, Rs2D, RdD;
  logic             PCSrcE;

  logic             ValidE;
  logic             RegWriteE;
  logic [1:0]       ResultSrcE;
  logic             MemWriteE;
  logic             ALUSrcE;
  logic [3:0]       ALUControlE;
  logic             BranchE;
  logic             JumpE;
  logic [XLEN-1:0]  RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]       Rs1E, Rs2E, RdE;
  logic             StallF, StallD, FlushD, FlushE;
  logic [CNT_W-1:0] LoadUseCnt, RedirectCnt;

  modport slave (
    input  ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, ALUControlD,
           BranchD, JumpD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           PCSrcE,
    output ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE,
           BranchE, JumpE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           StallF, StallD, FlushD, FlushE, LoadUseCnt, RedirectCnt
  );

  modport master (
    output ValidD, RegWriteD, ResultSrcD, MemWriteD, ALUSrcD, ALUControlD,
           BranchD, JumpD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
           PCSrcE,
    input  ValidE, RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, ALUControlE,
           BranchE, JumpE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           StallF, StallD, FlushD, FlushE, LoadUseCnt, RedirectCnt
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detection and stall/flush generation; a redirect from
// EX overrides the stall since the decode instruction is then wrong-path.
module hazard_detect
  import rv_pkg::*;
(
  input  logic        valid_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic        valid_e,
  input  result_src_t result_src_e,
  input  logic [4:0]  rd_e,
  input  logic        pc_src_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e
);

  logic lw_stall;

  // Raw rs fields are compared regardless of format; spurious stalls are harmless.
  assign lw_stall = valid_e && (result_src_e == RES_MEM) && (rd_e != 5'd0) &&
                    ((rs1_d == rd_e) || (rs2_d == rd_e)) && valid_d;

  assign stall_f = lw_stall & ~pc_src_e;
  assign stall_d = lw_stall & ~pc_src_e;
  assign flush_d = pc_src_e;
  assign flush_e = lw_stall | pc_src_e;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on flush, plus saturating
// load-use and redirect event counters.
module id_ex_stage #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);
  import rv_pkg::*;

  ctrl_t            ctrl_p0, ctrl_p1;
  logic             vld_p1;
  logic [XLEN-1:0]  rd1_p1, rd2_p1, pc_p1, pc4_p1, imm_p1;
  logic [4:0]       rs1_p1, rs2_p1, rd_p1;
  logic [CNT_W-1:0] load_use_cnt, redirect_cnt;
  logic             stall_f, stall_d, flush_d, flush_e;

  assign ctrl_p0 = '{reg_write:   bus.RegWriteD,
                     result_src:  result_src_t'(bus.ResultSrcD),
                     mem_write:   bus.MemWriteD,
                     alu_src:     bus.ALUSrcD,
                     alu_control: bus.ALUControlD,
                     branch:      bus.BranchD,
                     jump:        bus.JumpD};

  hazard_detect u_hazard (
    .valid_d      (bus.ValidD),
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .valid_e      (vld_p1),
    .result_src_e (ctrl_p1.result_src),
    .rd_e         (rd_p1),
    .pc_src_e     (bus.PCSrcE),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .flush_e      (flush_e)
  );

  // ---- ID -> EX boundary: a flush loads an all-zero bubble ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      pc_p1   <= '0;
      pc4_p1  <= '0;
      imm_p1  <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else if (flush_e) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      rd1_p1  <= '0;
      rd2_p1  <= '0;
      pc_p1   <= '0;
      pc4_p1  <= '0;
      imm_p1  <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else begin
      vld_p1  <= bus.ValidD;
      ctrl_p1 <= ctrl_p0;
      rd1_p1  <= bus.RD1D;
      rd2_p1  <= bus.RD2D;
      pc_p1   <= bus.PCD;
      pc4_p1  <= bus.PCPlus4D;
      imm_p1  <= bus.ImmExtD;
      rs1_p1  <= bus.Rs1D;
      rs2_p1  <= bus.Rs2D;
      rd_p1   <= bus.RdD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_use_cnt <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_f && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + 1'b1;
      if (bus.PCSrcE && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

  assign bus.ValidE      = vld_p1;
  assign bus.RegWriteE   = ctrl_p1.reg_write;
  assign bus.ResultSrcE  = ctrl_p1.result_src;
  assign bus.MemWriteE   = ctrl_p1.mem_write;
  assign bus.ALUSrcE     = ctrl_p1.alu_src;
  assign bus.ALUControlE = ctrl_p1.alu_control;
  assign bus.BranchE     = ctrl_p1.branch;
  assign bus.JumpE       = ctrl_p1.jump;
  assign bus.RD1E        = rd1_p1;
  assign bus.RD2E        = rd2_p1;
  assign bus.PCE         = pc_p1;
  assign bus.PCPlus4E    = pc4_p1;
  assign bus.ImmExtE     = imm_p1;
  assign bus.Rs1E        = rs1_p1;
  assign bus.Rs2E        = rs2_p1;
  assign bus.RdE         = rd_p1;
  assign bus.StallF      = stall_f;
  assign bus.StallD      = stall_d;
  assign bus.FlushD      = flush_d;
  assign bus.FlushE      = flush_e;
  assign bus.LoadUseCnt  = load_use_cnt;
  assign bus.RedirectCnt = redirect_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios, counter saturation on a
// narrow-counter instance, and randomized traffic against a reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        alu_src;
    logic [3:0]  alu_control;
    logic        branch;
    logic        jump;
    logic [63:0] rd1, rd2, pc, pc4, imm;
    logic [4:0]  rs1, rs2, rd;
  } e_t;

  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.XLEN(64), .CNT_W(16)) bus ();
  id_ex_stage_if #(.XLEN(64), .CNT_W(4))  bus4 ();

  id_ex_stage #(.XLEN(64), .CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.XLEN(64), .CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  function automatic e_t d_now();
    e_t d;
    d = '{valid: bus.ValidD, reg_write: bus.RegWriteD, result_src: bus.ResultSrcD,
          mem_write: bus.MemWriteD, alu_src: bus.ALUSrcD, alu_control: bus.ALUControlD,
          branch: bus.BranchD, jump: bus.JumpD, rd1: bus.RD1D, rd2: bus.RD2D,
          pc: bus.PCD, pc4: bus.PCPlus4D, imm: bus.ImmExtD,
          rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD};
    return d;
  endfunction

  function automatic e_t e_now();
    e_t e;
    e = '{valid: bus.ValidE, reg_write: bus.RegWriteE, result_src: bus.ResultSrcE,
          mem_write: bus.MemWriteE, alu_src: bus.ALUSrcE, alu_control: bus.ALUControlE,
          branch: bus.BranchE, jump: bus.JumpE, rd1: bus.RD1E, rd2: bus.RD2E,
          pc: bus.PCE, pc4: bus.PCPlus4E, imm: bus.ImmExtE,
          rs1: bus.Rs1E, rs2: bus.Rs2E, rd: bus.RdE};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_instr(input logic v, input logic rw, input logic [1:0] rsrc,
                           input logic [3:0] ctl, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] rd, input logic [63:0] pc);
    bus.ValidD      = v;
    bus.RegWriteD   = rw;
    bus.ResultSrcD  = rsrc;
    bus.MemWriteD   = 1'b0;
    bus.ALUSrcD     = 1'b0;
    bus.ALUControlD = ctl;
    bus.BranchD     = 1'b0;
    bus.JumpD       = 1'b0;
    bus.RD1D        = {$urandom, $urandom};
    bus.RD2D        = {$urandom, $urandom};
    bus.PCD         = pc;
    bus.PCPlus4D    = pc + 64'd4;
    bus.ImmExtD     = 64'd0;
    bus.Rs1D        = r1;
    bus.Rs2D        = r2;
    bus.RdD         = rd;
  endtask

  task automatic test_reset();
    set_instr(1'b1, 1'b1, 2'b10, 4'd5, 5'd1, 5'd2, 5'd3, 64'h200);
    bus.MemWriteD = 1'b1; bus.ALUSrcD = 1'b1; bus.BranchD = 1'b1; bus.JumpD = 1'b1;
    bus.ImmExtD = 64'h55;
    bus.PCSrcE = 1'b1;
    tick();
    bus.PCSrcE = 1'b0;
    tick();
    checks++;
    if (bus.RdE !== 5'd3 || bus.RedirectCnt !== 16'd1) begin
      errors++;
      $display("FAIL reset_precond: RdE=%0d RedirectCnt=%0d, want 3 and 1", bus.RdE, bus.RedirectCnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (e_now() !== e_t'('0)) begin
      errors++;
      $display("FAIL reset_e_clear: got %h want 0", e_now());
    end
    checks++;
    if (bus.LoadUseCnt !== 16'd0 || bus.RedirectCnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: lu=%0d rr=%0d want 0 0", bus.LoadUseCnt, bus.RedirectCnt);
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd3 || bus.PCE !== 64'h200) begin
      errors++;
      $display("FAIL reset_release_capture: ValidE=%0b RdE=%0d PCE=%h want 1 3 200",
               bus.ValidE, bus.RdE, bus.PCE);
    end
  endtask

  task automatic test_passthrough();
    logic [63:0] rd1;
    set_instr(1'b1, 1'b1, 2'b00, 4'd0, 5'd1, 5'd2, 5'd5, 64'h100);
    rd1 = bus.RD1D;
    #1;
    checks++;
    if (bus.StallF !== 1'b0 || bus.FlushE !== 1'b0) begin
      errors++;
      $display("FAIL pass_no_stall: StallF=%0b FlushE=%0b want 0 0", bus.StallF, bus.FlushE);
    end
    tick();
    checks++;
    if (bus.RdE !== 5'd5 || bus.PCE !== 64'h100 || bus.ValidE !== 1'b1 ||
        bus.RegWriteE !== 1'b1 || bus.ALUControlE !== 4'd0 || bus.RD1E !== rd1 ||
        bus.PCPlus4E !== 64'h104) begin
      errors++;
      $display("FAIL pass_add: RdE=%0d PCE=%h ValidE=%0b RD1E=%h want 5 100 1 %h",
               bus.RdE, bus.PCE, bus.ValidE, bus.RD1E, rd1);
    end
    set_instr(1'b1, 1'b1, 2'b00, 4'd1, 5'd5, 5'd3, 5'd6, 64'h104);
    #1;
    checks++;
    if (bus.StallF !== 1'b0) begin
      errors++;
      $display("FAIL pass_second_no_stall: StallF=%0b want 0", bus.StallF);
    end
    tick();
    checks++;
    if (bus.RdE !== 5'd6 || bus.ALUControlE !== 4'd1 || bus.Rs1E !== 5'd5) begin
      errors++;
      $display("FAIL pass_sub: RdE=%0d ALUControlE=%0d Rs1E=%0d want 6 1 5",
               bus.RdE, bus.ALUControlE, bus.Rs1E);
    end
  endtask

  task automatic test_x0_load();
    set_instr(1'b1, 1'b1, 2'b01, 4'd0, 5'd2, 5'd0, 5'd0, 64'h300);
    tick();
    set_instr(1'b1, 1'b1, 2'b00, 4'd0, 5'd0, 5'd0, 5'd9, 64'h304);
    #1;
    checks++;
    if (bus.StallF !== 1'b0 || bus.StallD !== 1'b0 || bus.FlushE !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_stall: StallF=%0b StallD=%0b FlushE=%0b want 0 0 0",
               bus.StallF, bus.StallD, bus.FlushE);
    end
    tick();
    checks++;
    if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd9 || bus.LoadUseCnt !== 16'd0) begin
      errors++;
      $display("FAIL x0_consumer: ValidE=%0b RdE=%0d lu=%0d want 1 9 0",
               bus.ValidE, bus.RdE, bus.LoadUseCnt);
    end
  endtask

  task automatic test_load_use();
    set_instr(1'b1, 1'b1, 2'b01, 4'd0, 5'd2, 5'd0, 5'd7, 64'h400);
    tick();
    set_instr(1'b1, 1'b1, 2'b00, 4'd0, 5'd7, 5'd3, 5'd8, 64'h404);
    #1;
    checks++;
    if (bus.StallF !== 1'b1 || bus.StallD !== 1'b1 || bus.FlushE !== 1'b1 || bus.FlushD !== 1'b0) begin
      errors++;
      $display("FAIL lu_hazard: StallF=%0b StallD=%0b FlushE=%0b FlushD=%0b want 1 1 1 0",
               bus.StallF, bus.StallD, bus.FlushE, bus.FlushD);
    end
    tick();
    checks++;
    if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.RdE !== 5'd0 || bus.LoadUseCnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_bubble: ValidE=%0b RegWriteE=%0b RdE=%0d lu=%0d want 0 0 0 1",
               bus.ValidE, bus.RegWriteE, bus.RdE, bus.LoadUseCnt);
    end
    checks++;
    if (bus.StallF !== 1'b0 || bus.FlushE !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble_no_stall: StallF=%0b FlushE=%0b want 0 0", bus.StallF, bus.FlushE);
    end
    tick();
    checks++;
    if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd8 || bus.Rs1E !== 5'd7 || bus.LoadUseCnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_consumer_enters: ValidE=%0b RdE=%0d Rs1E=%0d lu=%0d want 1 8 7 1",
               bus.ValidE, bus.RdE, bus.Rs1E, bus.LoadUseCnt);
    end
  endtask

  task automatic test_redirect_load_use();
    do_reset();
    set_instr(1'b1, 1'b1, 2'b01, 4'd0, 5'd2, 5'd0, 5'd7, 64'h500);
    tick();
    set_instr(1'b1, 1'b1, 2'b00, 4'd0, 5'd7, 5'd3, 5'd8, 64'h504);
    bus.PCSrcE = 1'b1;
    #1;
    checks++;
    if (bus.StallF !== 1'b0 || bus.StallD !== 1'b0 || bus.FlushD !== 1'b1 || bus.FlushE !== 1'b1) begin
      errors++;
      $display("FAIL redir_hazard: StallF=%0b StallD=%0b FlushD=%0b FlushE=%0b want 0 0 1 1",
               bus.StallF, bus.StallD, bus.FlushD, bus.FlushE);
    end
    tick();
    bus.PCSrcE = 1'b0;
    checks++;
    if (bus.ValidE !== 1'b0 || bus.RedirectCnt !== 16'd1 || bus.LoadUseCnt !== 16'd0) begin
      errors++;
      $display("FAIL redir_bubble: ValidE=%0b rr=%0d lu=%0d want 0 1 0",
               bus.ValidE, bus.RedirectCnt, bus.LoadUseCnt);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    bus4.PCSrcE = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i > 15) ? 15 : i;
      checks++;
      if (bus4.RedirectCnt !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_redirect[%0d]: got %0d want %0d", i, bus4.RedirectCnt, exp_cnt);
      end
    end
    bus4.PCSrcE = 1'b0;
    tick();
    checks++;
    if (bus4.RedirectCnt !== 4'd15 || bus4.LoadUseCnt !== 4'd0) begin
      errors++;
      $display("FAIL sat_hold: rr=%0d lu=%0d want 15 0", bus4.RedirectCnt, bus4.LoadUseCnt);
    end
  endtask

  task automatic test_random();
    e_t   m_e, d_snap;
    int   m_lu, m_rr;
    logic exp_lw, pc;
    logic [3:0] exp_haz;
    do_reset();
    m_e = '0; m_lu = 0; m_rr = 0;
    for (int i = 0; i < 400; i++) begin
      bus.ValidD      = ($urandom_range(0, 5) != 0);
      bus.RegWriteD   = 1'($urandom);
      bus.ResultSrcD  = 2'($urandom_range(0, 2));
      bus.MemWriteD   = 1'($urandom);
      bus.ALUSrcD     = 1'($urandom);
      bus.ALUControlD = 4'($urandom_range(0, 6));
      bus.BranchD     = 1'($urandom);
      bus.JumpD       = 1'($urandom);
      bus.RD1D        = {$urandom, $urandom};
      bus.RD2D        = {$urandom, $urandom};
      bus.PCD         = {$urandom, $urandom};
      bus.PCPlus4D    = {$urandom, $urandom};
      bus.ImmExtD     = {$urandom, $urandom};
      bus.Rs1D        = 5'($urandom_range(0, 5));
      bus.Rs2D        = 5'($urandom_range(0, 5));
      bus.RdD         = 5'($urandom_range(0, 5));
      bus.PCSrcE      = ($urandom_range(0, 7) == 0);
      #1;
      pc = bus.PCSrcE;
      exp_lw = m_e.valid && (m_e.result_src == 2'b01) && (m_e.rd != 5'd0) &&
               ((bus.Rs1D == m_e.rd) || (bus.Rs2D == m_e.rd)) && bus.ValidD;
      exp_haz = {exp_lw & ~pc, exp_lw & ~pc, pc, exp_lw | pc};
      checks++;
      if ({bus.StallF, bus.StallD, bus.FlushD, bus.FlushE} !== exp_haz) begin
        errors++;
        $display("FAIL rand_hazard[%0d]: got %b want %b", i,
                 {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE}, exp_haz);
      end
      d_snap = d_now();
      @(posedge clk);
      if (exp_lw && !pc && m_lu < CNT_MAX) m_lu++;
      if (pc && m_rr < CNT_MAX) m_rr++;
      m_e = (exp_lw || pc) ? e_t'('0) : d_snap;
      #1;
      checks++;
      if (e_now() !== m_e) begin
        errors++;
        $display("FAIL rand_e[%0d]: got %h want %h", i, e_now(), m_e);
      end
      checks++;
      if (bus.LoadUseCnt !== 16'(m_lu) || bus.RedirectCnt !== 16'(m_rr)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: lu=%0d rr=%0d want %0d %0d", i,
                 bus.LoadUseCnt, bus.RedirectCnt, m_lu, m_rr);
      end
    end
    bus.PCSrcE = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    set_instr(1'b0, 1'b0, 2'b00, 4'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    bus.PCSrcE = 1'b0;
    bus4.ValidD = 1'b0; bus4.RegWriteD = 1'b0; bus4.ResultSrcD = 2'b00;
    bus4.MemWriteD = 1'b0; bus4.ALUSrcD = 1'b0; bus4.ALUControlD = 4'd0;
    bus4.BranchD = 1'b0; bus4.JumpD = 1'b0;
    bus4.RD1D = '0; bus4.RD2D = '0; bus4.PCD = '0; bus4.PCPlus4D = '0; bus4.ImmExtD = '0;
    bus4.Rs1D = '0; bus4.Rs2D = '0; bus4.RdD = '0; bus4.PCSrcE = 1'b0;
    #3 rst_n = 1'b1;

    test_reset();
    test_passthrough();
    test_x0_load();
    test_load_use();
    test_redirect_load_use();
    test_saturation();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
